// File: rtl/seg7_msg_decoder_pkg.sv
// Shared constants for the rotating-word display checker: segment patterns,
// character codes, rotation sentinel, FSM encoding and the word rotator.
package seg7_msg_decoder_pkg;

  // Active-low patterns written in segment order a..g (leftmost literal bit = seg a)
  localparam logic [6:0] SEG_H     = 7'b1001000;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] CH_H     = 3'd0;
  localparam logic [2:0] CH_E     = 3'd1;
  localparam logic [2:0] CH_L     = 3'd2;
  localparam logic [2:0] CH_O     = 3'd3;
  localparam logic [2:0] CH_BLANK = 3'd4;

  localparam logic [2:0] ROT_NONE = 3'd7;
  localparam logic [2:0] ROT_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEARCH = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Left-rotate a five-character word by k characters (3*k bits)
  function automatic logic [14:0] rotl_word(input logic [14:0] w, input logic [2:0] k);
    logic [14:0] r;
    case (k)
      3'd1:    r = {w[11:0], w[14:12]};
      3'd2:    r = {w[8:0],  w[14:9]};
      3'd3:    r = {w[5:0],  w[14:6]};
      3'd4:    r = {w[2:0],  w[14:3]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_msg_decoder_seg7_to_char.sv
// Combinational reverse map of one active-low 7-segment pattern to its character
// code; unknown patterns read as blank and raise the bad flag.
module seg7_to_char
  import seg7_msg_decoder_pkg::*;
(
  input  logic [0:6] seg,
  output logic [2:0] code,
  output logic       bad
);

  always_comb begin
    code = CH_BLANK;
    bad  = 1'b0;
    case (seg)
      SEG_H:     code = CH_H;
      SEG_E:     code = CH_E;
      SEG_L:     code = CH_L;
      SEG_O:     code = CH_O;
      SEG_BLANK: code = CH_BLANK;
      default:   bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_msg_decoder.sv
// Receive-side checker: waits for the five display digits to settle, decodes them
// and reports which left-rotation of RefMsg they show over a valid/ready handshake.
module seg7_msg_decoder
  import seg7_msg_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CW            = 5
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [0:6]  HEX4,
  input  logic [0:6]  HEX3,
  input  logic [0:6]  HEX2,
  input  logic [0:6]  HEX1,
  input  logic [0:6]  HEX0,
  input  logic [14:0] RefMsg,
  input  logic        Ready,
  output logic        Valid,
  output logic [14:0] Codes,
  output logic [2:0]  Rot,
  output logic        Match,
  output logic        BadSeg
);

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [34:0]   sample_p0;
  logic [34:0]   sample_p1;
  logic          change;
  logic [14:0]   dec_codes;
  logic [4:0]    dec_bad;
  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [2:0]    k;
  logic          pend;

  // Stage p0: raw display capture; p1: previous capture for change detection
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sample_p0 <= '1;
      sample_p1 <= '1;
    end else begin
      sample_p0 <= {HEX4, HEX3, HEX2, HEX1, HEX0};
      sample_p1 <= sample_p0;
    end
  end

  assign change     = (sample_p0 != sample_p1);
  assign count_next = (count == CNT_MAX) ? count : count + 1'b1;

  for (genvar d = 0; d < 5; d++) begin : g_dec
    seg7_to_char u_dec (
      .seg  (sample_p0[7*d +: 7]),
      .code (dec_codes[3*d +: 3]),
      .bad  (dec_bad[d])
    );
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      Valid  <= 1'b0;
      Codes  <= '0;
      Rot    <= ROT_NONE;
      Match  <= 1'b0;
      BadSeg <= 1'b0;
      count  <= '0;
      k      <= '0;
      pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (change) begin
            state <= SETTLE;
            count <= '0;
          end
        end

        SETTLE: begin
          if (change) begin
            count <= '0;
          end else begin
            count <= count_next;
            if (count_next >= CNT_LAST) begin
              state  <= SEARCH;
              k      <= '0;
              Codes  <= dec_codes;
              BadSeg <= |dec_bad;
              Rot    <= ROT_NONE;
              Match  <= 1'b0;
              pend   <= 1'b0;
            end
          end
        end

        SEARCH: begin
          if (change) pend <= 1'b1;
          if (rotl_word(RefMsg, k) == Codes) begin
            Rot   <= k;
            Match <= 1'b1;
            Valid <= 1'b1;
            state <= REPORT;
          end else if (k == ROT_LAST) begin
            Rot   <= ROT_NONE;
            Match <= 1'b0;
            Valid <= 1'b1;
            state <= REPORT;
          end else begin
            k <= k + 3'd1;
          end
        end

        REPORT: begin
          if (Ready) begin
            // A change seen while busy (or on this very cycle) restarts settling
            Valid <= 1'b0;
            count <= '0;
            pend  <= 1'b0;
            state <= (pend || change) ? SETTLE : IDLE;
          end else if (change) begin
            pend <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
